// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: merges the never-stalling pipeline writeback and the mul/div result
// stream onto the single register-file write port, buffering displaced mul/div results in age order.
module wb_arbiter #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned REG_COUNT     = 32,
  parameter int unsigned BUF_DEPTH     = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               pipe_valid_i,
  input  logic [REG_IDX_WIDTH-1:0]           pipe_addr_i,
  input  logic [WORD_LEN-1:0]                pipe_data_i,
  input  logic                               md_valid_i,
  output logic                               md_ready_o,
  input  logic [REG_IDX_WIDTH-1:0]           md_addr_i,
  input  logic [WORD_LEN-1:0]                md_data_i,
  output logic                               write_enable_o,
  output logic [REG_IDX_WIDTH-1:0]           write_addr_o,
  output logic [WORD_LEN-1:0]                write_data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     pending_count_o,
  output logic [REG_COUNT-1:0]               pending_mask_o
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IdxW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Buffer is kept compacted: entries [0, count_q) are valid, index 0 is the oldest.
  logic [REG_IDX_WIDTH-1:0] buf_addr_q [BUF_DEPTH];
  logic [REG_IDX_WIDTH-1:0] buf_addr_d [BUF_DEPTH];
  logic [WORD_LEN-1:0]      buf_data_q [BUF_DEPTH];
  logic [WORD_LEN-1:0]      buf_data_d [BUF_DEPTH];
  logic [CntW-1:0]          count_q, count_d;

  logic                     we_q, we_d;
  logic [REG_IDX_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_LEN-1:0]      wdata_q, wdata_d;

  logic        pipe_win, md_acc, md_live, pop, bypass, push;
  int unsigned n;

  always_comb begin
    pipe_win   = pipe_valid_i && (pipe_addr_i != '0);
    md_ready_o = !reset_i && (count_q < CntW'(BUF_DEPTH));
    md_acc     = md_valid_i && md_ready_o;
    // x0 results and results overwritten by a younger pipeline write are consumed silently.
    md_live    = md_acc && (md_addr_i != '0) && !(pipe_win && (md_addr_i == pipe_addr_i));
    pop        = !pipe_win && (count_q != '0);
    bypass     = !pipe_win && (count_q == '0) && md_live;
    push       = md_live && !bypass;

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_win) begin
      we_d    = 1'b1;
      waddr_d = pipe_addr_i;
      wdata_d = pipe_data_i;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = buf_addr_q[0];
      wdata_d = buf_data_q[0];
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = md_addr_i;
      wdata_d = md_data_i;
    end

    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    n          = 0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      if ((CntW'(i) < count_q) && !(pipe_win && (buf_addr_q[i] == pipe_addr_i)) &&
          !(pop && (i == 0))) begin
        buf_addr_d[IdxW'(n)] = buf_addr_q[i];
        buf_data_d[IdxW'(n)] = buf_data_q[i];
        n                    = n + 1;
      end
    end
    if (push && (n < BUF_DEPTH)) begin
      buf_addr_d[IdxW'(n)] = md_addr_i;
      buf_data_d[IdxW'(n)] = md_data_i;
      n                    = n + 1;
    end
    count_d = CntW'(n);
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      if (CntW'(i) < count_q) begin
        pending_mask_o = pending_mask_o | (REG_COUNT'(1) << buf_addr_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign write_enable_o  = we_q;
  assign write_addr_o    = waddr_q;
  assign write_data_o    = wdata_q;
  assign pending_count_o = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for steady-state arbitration plus
// hand-written reset sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, md_valid, md_ready, write_enable;
  logic [4:0]  pipe_addr, md_addr, write_addr;
  logic [31:0] pipe_data, md_data, write_data, pending_mask;
  logic [1:0]  pending_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .WORD_LEN     (32),
    .REG_IDX_WIDTH(5),
    .REG_COUNT    (32),
    .BUF_DEPTH    (2)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .pipe_valid_i   (pipe_valid),
    .pipe_addr_i    (pipe_addr),
    .pipe_data_i    (pipe_data),
    .md_valid_i     (md_valid),
    .md_ready_o     (md_ready),
    .md_addr_i      (md_addr),
    .md_data_i      (md_data),
    .write_enable_o (write_enable),
    .write_addr_o   (write_addr),
    .write_data_o   (write_data),
    .pending_count_o(pending_count),
    .pending_mask_o (pending_mask)
  );

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  cnt;
    logic [31:0] mask;
    logic        rdy;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    md_valid   = 1'b0; md_addr   = '0; md_data   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {pv, pa, pd, mv, ma, md, we, wa, wd, cnt, mask, rdy}
    vecs[0]  = '{0, 0, 0,      1, 5,  32'hDEADBEEF, 1, 5,  32'hDEADBEEF, 0, 0,         1};
    vecs[1]  = '{0, 0, 0,      0, 0,  0,            0, 5,  32'hDEADBEEF, 0, 0,         1};
    vecs[2]  = '{1, 3, 1,      1, 7,  2,            1, 3,  1,            1, 32'h80,    1};
    vecs[3]  = '{0, 0, 0,      0, 0,  0,            1, 7,  2,            0, 0,         1};
    vecs[4]  = '{0, 0, 0,      0, 0,  0,            0, 7,  2,            0, 0,         1};
    vecs[5]  = '{1, 1, 32'h101, 1, 10, 32'hA0,      1, 1,  32'h101,      1, 32'h400,   1};
    vecs[6]  = '{1, 2, 32'h102, 1, 11, 32'hB0,      1, 2,  32'h102,      2, 32'hC00,   0};
    vecs[7]  = '{1, 3, 32'h103, 1, 12, 32'hC0,      1, 3,  32'h103,      2, 32'hC00,   0};
    vecs[8]  = '{1, 4, 32'h104, 1, 12, 32'hC0,      1, 4,  32'h104,      2, 32'hC00,   0};
    vecs[9]  = '{0, 0, 0,      1, 12, 32'hC0,       1, 10, 32'hA0,       1, 32'h800,   1};
    vecs[10] = '{0, 0, 0,      1, 12, 32'hC0,       1, 11, 32'hB0,       1, 32'h1000,  1};
    vecs[11] = '{0, 0, 0,      0, 0,  0,            1, 12, 32'hC0,       0, 0,         1};
    vecs[12] = '{1, 1, 1,      1, 9,  32'h99,       1, 1,  1,            1, 32'h200,   1};
    vecs[13] = '{1, 9, 32'h55, 0, 0,  0,            1, 9,  32'h55,       0, 0,         1};
    vecs[14] = '{0, 0, 0,      0, 0,  0,            0, 9,  32'h55,       0, 0,         1};
    vecs[15] = '{1, 6, 32'h66, 1, 6,  32'h77,       1, 6,  32'h66,       0, 0,         1};
    vecs[16] = '{0, 0, 0,      0, 0,  0,            0, 6,  32'h66,       0, 0,         1};
    vecs[17] = '{1, 1, 1,      1, 4,  32'h44,       1, 1,  1,            1, 32'h10,    1};
    vecs[18] = '{1, 0, 32'hBAD, 0, 0, 0,            1, 4,  32'h44,       0, 0,         1};
    vecs[19] = '{0, 0, 0,      1, 0,  32'h123,      0, 4,  32'h44,       0, 0,         1};
    vecs[20] = '{0, 0, 0,      0, 0,  0,            0, 4,  32'h44,       0, 0,         1};

    idle_inputs();
    reset = 1'b1;
    tick();
    check("rst.ready_during_reset", {31'b0, md_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst.ready_after_release", {31'b0, md_ready}, 32'd1);
    check("rst.we",    {31'b0, write_enable}, 32'd0);
    check("rst.waddr", {27'b0, write_addr},   32'd0);
    check("rst.wdata", write_data,            32'd0);
    check("rst.count", {30'b0, pending_count}, 32'd0);
    check("rst.mask",  pending_mask,          32'd0);

    for (int i = 0; i < 21; i++) begin
      pipe_valid = vecs[i].pv; pipe_addr = vecs[i].pa; pipe_data = vecs[i].pd;
      md_valid   = vecs[i].mv; md_addr   = vecs[i].ma; md_data   = vecs[i].md;
      tick();
      check($sformatf("v%0d.we", i),    {31'b0, write_enable},  {31'b0, vecs[i].we});
      check($sformatf("v%0d.waddr", i), {27'b0, write_addr},    {27'b0, vecs[i].wa});
      check($sformatf("v%0d.wdata", i), write_data,             vecs[i].wd);
      check($sformatf("v%0d.count", i), {30'b0, pending_count}, {30'b0, vecs[i].cnt});
      check($sformatf("v%0d.mask", i),  pending_mask,           vecs[i].mask);
      check($sformatf("v%0d.ready", i), {31'b0, md_ready},      {31'b0, vecs[i].rdy});
    end

    // Reset with two results buffered: they must be lost and never written.
    pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h1;
    md_valid   = 1'b1; md_addr   = 5'd20; md_data  = 32'h14;
    tick();
    pipe_addr = 5'd2; pipe_data = 32'h2;
    md_addr   = 5'd21; md_data  = 32'h15;
    tick();
    check("mid.count_full", {30'b0, pending_count}, 32'd2);
    check("mid.mask_full",  pending_mask,           32'h0030_0000);
    idle_inputs();
    reset = 1'b1;
    tick();
    check("mid.we_first_reset_edge", {31'b0, write_enable},  32'd0);
    check("mid.count_reset",         {30'b0, pending_count}, 32'd0);
    check("mid.mask_reset",          pending_mask,           32'd0);
    check("mid.waddr_reset",         {27'b0, write_addr},    32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid.post%0d.we", i),    {31'b0, write_enable},  32'd0);
      check($sformatf("mid.post%0d.count", i), {30'b0, pending_count}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
